// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared scancode constants, receive FSM state type and clock glitch filter step
// Contents:
//   SC_*           set-2 scancodes with special meaning to the decoder
//   rx_state_e     receive FSM states
//   filt_t         filtered-clock level plus run-length counter
//   next_filtered  one clock step of the glitch filter
package ps2_kbd_pkg;

    localparam logic [7:0] SC_F0       = 8'hF0;
    localparam logic [7:0] SC_E0       = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       lvl;
        logic [7:0] cnt;
    } filt_t;

    // The level flips only after len consecutive samples that differ from it;
    // any sample equal to the current level restarts the run.
    function automatic filt_t next_filtered(filt_t cur, logic smp, logic [7:0] len);
        filt_t n;
        n = cur;
        if (smp == cur.lvl) begin
            n.cnt = '0;
        end else if (cur.cnt == len - 8'd1) begin
            n.lvl = smp;
            n.cnt = '0;
        end else begin
            n.cnt = cur.cnt + 8'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ps2_kbd_if.sv
// ps2_kbd_if: CPU-side character handshake of the keyboard controller
// Signals:
//   cpu_intr   character available (controller -> CPU)
//   ascii_out  character at the FIFO head (controller -> CPU)
//   cpu_ack    four-phase acknowledge level (CPU -> controller)
// Modports: master = controller side, slave = CPU side.
interface ps2_kbd_if;

    logic       cpu_intr;
    logic [7:0] ascii_out;
    logic       cpu_ack;

    modport master (output cpu_intr, output ascii_out, input cpu_ack);
    modport slave  (input cpu_intr, input ascii_out, output cpu_ack);

endinterface

// File: rtl/ps2_scancode_to_ascii.sv
// ps2_scancode_to_ascii: combinational set-2 make code to ascii lookup
module ps2_scancode_to_ascii (
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic       valid_o,
  output logic [7:0] ascii_o
);
  logic [16:0] e;
  always_comb begin
    case (code_i)
      8'h1C: e = {1'b1, "a", "A"};
      8'h32: e = {1'b1, "b", "B"};
      8'h21: e = {1'b1, "c", "C"};
      8'h23: e = {1'b1, "d", "D"};
      8'h24: e = {1'b1, "e", "E"};
      8'h2B: e = {1'b1, "f", "F"};
      8'h34: e = {1'b1, "g", "G"};
      8'h33: e = {1'b1, "h", "H"};
      8'h43: e = {1'b1, "i", "I"};
      8'h3B: e = {1'b1, "j", "J"};
      8'h42: e = {1'b1, "k", "K"};
      8'h4B: e = {1'b1, "l", "L"};
      8'h3A: e = {1'b1, "m", "M"};
      8'h31: e = {1'b1, "n", "N"};
      8'h44: e = {1'b1, "o", "O"};
      8'h4D: e = {1'b1, "p", "P"};
      8'h15: e = {1'b1, "q", "Q"};
      8'h2D: e = {1'b1, "r", "R"};
      8'h1B: e = {1'b1, "s", "S"};
      8'h2C: e = {1'b1, "t", "T"};
      8'h3C: e = {1'b1, "u", "U"};
      8'h2A: e = {1'b1, "v", "V"};
      8'h1D: e = {1'b1, "w", "W"};
      8'h22: e = {1'b1, "x", "X"};
      8'h35: e = {1'b1, "y", "Y"};
      8'h1A: e = {1'b1, "z", "Z"};
      8'h16: e = {1'b0, "1", "!"};
      8'h1E: e = {1'b0, "2", "@"};
      8'h26: e = {1'b0, "3", "#"};
      8'h25: e = {1'b0, "4", "$"};
      8'h2E: e = {1'b0, "5", "%"};
      8'h36: e = {1'b0, "6", "^"};
      8'h3D: e = {1'b0, "7", "&"};
      8'h3E: e = {1'b0, "8", "*"};
      8'h46: e = {1'b0, "9", "("};
      8'h45: e = {1'b0, "0", ")"};
      8'h0E: e = {1'b0, 8'h60, "~"};
      8'h4E: e = {1'b0, "-", "_"};
      8'h55: e = {1'b0, "=", "+"};
      8'h54: e = {1'b0, "[", "{"};
      8'h5B: e = {1'b0, "]", "}"};
      8'h5D: e = {1'b0, 8'h5C, "|"};
      8'h4C: e = {1'b0, ";", ":"};
      8'h52: e = {1'b0, "'", 8'h22};
      8'h41: e = {1'b0, ",", "<"};
      8'h49: e = {1'b0, ".", ">"};
      8'h4A: e = {1'b0, "/", "?"};
      8'h29: e = {1'b0, " ", " "};
      8'h5A: e = {1'b0, 8'h0D, 8'h0D};
      8'h0D: e = {1'b0, 8'h09, 8'h09};
      8'h66: e = {1'b0, 8'h08, 8'h08};
      8'h76: e = {1'b0, 8'h1B, 8'h1B};
      default: e = '0;
    endcase
  end
  assign valid_o = e[15:8] != 8'h00;
  assign ascii_o = (e[16] ? shift_i ^ caps_i : shift_i) ? e[7:0] : e[15:8];
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard receiver, set-2 decoder and character FIFO with CPU intr/ack handshake
// Ports:
//   clk, rst           system clock, synchronous active-low reset
//   ps2_data, ps2_clk  asynchronous PS/2 lines
//   cpu                ps2_kbd_if.master: cpu_intr, ascii_out out, cpu_ack in
//   ps2_data_pulldown  always 0 (no host-to-device transmit)
//   ps2_clk_pulldown   inhibit the keyboard while the FIFO is full and the receiver idle
//   fifo_count         FIFO occupancy 0..FIFO_DEPTH
//   rx_err             1-cycle pulse on parity, stop-bit or timeout error
//   overflow           1-cycle pulse when a character is dropped on a full FIFO
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYC     = 5000,
    parameter int FIFO_DEPTH      = 16,
    parameter bit INHIBIT_ON_FULL = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_data,
    input  logic                        ps2_clk,
    ps2_kbd_if.master                   cpu,
    output logic                        ps2_data_pulldown,
    output logic                        ps2_clk_pulldown,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        rx_err,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    filt_t         filt_q, filt_d;
    logic          fall, din, tmo;
    rx_state_e     state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_q, bit_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          byte_vld_q, byte_vld_d;
    logic          err_q, err_d;
    logic          brk_q, brk_d, ext_q, ext_d, sh_q, sh_d, caps_q, caps_d;
    logic          push_q, push_d;
    logic [7:0]    chr_q, chr_d;
    logic          rom_vld;
    logic [7:0]    rom_chr;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          ack_q, ovf_q, full, pop, wr;

    // Synchronisers idle high so reset never produces a spurious falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= '{lvl: 1'b1, cnt: 8'd0};
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= filt_d;
        end
    end

    assign filt_d = next_filtered(filt_q, clk_sync_q[1], 8'(FILTER_LEN));
    assign fall   = filt_q.lvl & ~filt_d.lvl;
    assign din    = data_sync_q[1];
    assign tmo    = (state_q != RX_IDLE) && !fall && (to_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        state_q <= rst ? state_d : RX_IDLE;
    end

    always_comb begin
        state_d = state_q;
        if (tmo) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            case (state_q)
                RX_IDLE:   state_d = din ? RX_IDLE : RX_DATA;
                RX_DATA:   state_d = (bit_q == 3'd7) ? RX_PARITY : RX_DATA;
                RX_PARITY: state_d = RX_STOP;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        sr_d       = sr_q;
        bit_d      = bit_q;
        par_d      = par_q;
        to_d       = (state_q == RX_IDLE || fall) ? '0 : to_q + 1'b1;
        byte_vld_d = 1'b0;
        err_d      = tmo;
        if (fall) begin
            case (state_q)
                RX_IDLE: bit_d = '0;
                RX_DATA: begin
                    sr_d  = {din, sr_q[7:1]};
                    bit_d = bit_q + 3'd1;
                end
                RX_PARITY: par_d = ^{sr_q, din};
                default: begin
                    byte_vld_d = din & par_q;
                    err_d      = ~(din & par_q);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q       <= '0;
            bit_q      <= '0;
            par_q      <= 1'b0;
            to_q       <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            bit_q      <= bit_d;
            par_q      <= par_d;
            to_q       <= to_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    ps2_scancode_to_ascii u_rom (
        .code_i  (sr_q),
        .shift_i (sh_q),
        .caps_i  (caps_q),
        .valid_o (rom_vld),
        .ascii_o (rom_chr)
    );

    // Prefixes only set flags; the next non-prefix code consumes and clears them.
    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        sh_d   = sh_q;
        caps_d = caps_q;
        push_d = 1'b0;
        chr_d  = chr_q;
        if (byte_vld_q) begin
            if (sr_q == SC_F0) begin
                brk_d = 1'b1;
            end else if (sr_q == SC_E0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (sr_q == SC_LSHIFT || sr_q == SC_RSHIFT) begin
                    sh_d = ~brk_q;
                end else if (sr_q == SC_CAPS) begin
                    caps_d = caps_q ^ ~brk_q;
                end else if (!brk_q) begin
                    push_d = ext_q ? (sr_q == SC_KP_ENTER) : rom_vld;
                    chr_d  = ext_q ? 8'h0D : rom_chr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
            sh_q   <= 1'b0;
            caps_q <= 1'b0;
            push_q <= 1'b0;
            chr_q  <= 8'h00;
        end else begin
            brk_q  <= brk_d;
            ext_q  <= ext_d;
            sh_q   <= sh_d;
            caps_q <= caps_d;
            push_q <= push_d;
            chr_q  <= chr_d;
        end
    end

    // A pop is the rising edge of cpu_ack while a character is offered.
    assign full = cnt_q == (AW + 1)'(FIFO_DEPTH);
    assign pop  = cpu.cpu_ack & ~ack_q & (cnt_q != '0);
    assign wr   = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_q + AW'(wr);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
            ack_q <= cpu.cpu_ack;
            ovf_q <= push_q & full & ~pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= chr_q;
    end

    assign cpu.cpu_intr      = (cnt_q != '0) & ~cpu.cpu_ack;
    assign cpu.ascii_out     = (cnt_q != '0) ? mem_q[rd_q] : 8'h00;
    assign ps2_clk_pulldown  = INHIBIT_ON_FULL && full && (state_q == RX_IDLE);
    assign ps2_data_pulldown = 1'b0;
    assign fifo_count        = cnt_q;
    assign rx_err            = err_q;
    assign overflow          = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 5000;
    localparam int DEPTH       = 16;
    localparam int HALF        = 30;
    // 2 synchroniser stages + FILTER_LEN filter samples, then stop bit in N,
    // decoder N+1, FIFO write N+2, cpu_intr visible in N+3.
    localparam int LAT         = 2 + FILTER_LEN + 2;

    logic clk = 1'b0;
    logic rst;
    logic ps2_data, ps2_clk;
    logic ps2_data_pulldown, ps2_clk_pulldown, rx_err, overflow;
    logic [$clog2(DEPTH):0] fifo_count;
    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int e0, o0;
    logic [7:0] v;
    logic [7:0] codes [16] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};
    string drain = "cdefghijklmnoprs";

    ps2_kbd_if cpu_if ();

    ps2_kbd_ctrl #(
        .FILTER_LEN      (FILTER_LEN),
        .TIMEOUT_CYC     (TIMEOUT_CYC),
        .FIFO_DEPTH      (DEPTH),
        .INHIBIT_ON_FULL (1'b1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ps2_data          (ps2_data),
        .ps2_clk           (ps2_clk),
        .cpu               (cpu_if),
        .ps2_data_pulldown (ps2_data_pulldown),
        .ps2_clk_pulldown  (ps2_clk_pulldown),
        .fifo_count        (fifo_count),
        .rx_err            (rx_err),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_err) err_cnt++;
        if (overflow) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    // ack_at > 0 raises cpu_ack that many cycles after the stop-bit falling edge.
    task automatic send_frame(input logic [7:0] code, input logic bad_par = 1'b0, input int ack_at = 0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~^code ^ bad_par);
        ps2_data = 1'b1;
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        if (ack_at > 0) begin
            wait_cyc(ack_at);
            cpu_if.cpu_ack = 1'b1;
            wait_cyc(HALF - ack_at);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
        cpu_if.cpu_ack = 1'b0;
        wait_cyc(4);
    endtask

    task automatic ack_pulse();
        cpu_if.cpu_ack = 1'b1;
        wait_cyc(3);
        cpu_if.cpu_ack = 1'b0;
        wait_cyc(2);
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        wait_cyc(20);
    endtask

    initial begin
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cpu_if.cpu_ack = 1'b0;
        wait_cyc(4);
        check("rst_intr", cpu_if.cpu_intr, 0);
        check("rst_ascii", cpu_if.ascii_out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pd", {ps2_clk_pulldown, ps2_data_pulldown, rx_err, overflow}, 0);
        rst = 1'b1;
        wait_cyc(20);

        // single frame 1C with exact latency
        v = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(LAT - 1);
        check("lat_early_intr", cpu_if.cpu_intr, 0);
        wait_cyc(1);
        check("lat_intr", cpu_if.cpu_intr, 1);
        check("lat_ascii", cpu_if.ascii_out, 8'h61);
        wait_cyc(HALF - LAT);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
        cpu_if.cpu_ack = 1'b1;
        wait_cyc(1);
        check("ack_intr", cpu_if.cpu_intr, 0);
        check("ack_count", fifo_count, 0);
        cpu_if.cpu_ack = 1'b0;
        wait_cyc(2);

        // shift make/break sequence
        send_frame(8'h12); send_frame(8'h1C); send_frame(8'hF0); send_frame(8'h1C);
        send_frame(8'hF0); send_frame(8'h12); send_frame(8'h1C);
        check("seq_count", fifo_count, 2);
        check("seq_head0", cpu_if.ascii_out, 8'h41);
        cpu_if.cpu_ack = 1'b1;
        wait_cyc(5);
        check("held_ack_count", fifo_count, 1);
        check("held_ack_intr", cpu_if.cpu_intr, 0);
        cpu_if.cpu_ack = 1'b0;
        wait_cyc(1);
        check("reassert_intr", cpu_if.cpu_intr, 1);
        check("seq_head1", cpu_if.ascii_out, 8'h61);
        ack_pulse();
        check("seq_empty", fifo_count, 0);

        // caps lock toggle, break ignored, digits follow shift only
        send_frame(8'h58); send_frame(8'h1C);
        check("caps_on", cpu_if.ascii_out, 8'h41);
        ack_pulse();
        send_frame(8'hF0); send_frame(8'h58); send_frame(8'h16);
        check("caps_digit", cpu_if.ascii_out, 8'h31);
        ack_pulse();
        send_frame(8'h58); send_frame(8'h1C);
        check("caps_off", cpu_if.ascii_out, 8'h61);
        ack_pulse();

        // bad parity
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        check("badpar_err", err_cnt - e0, 1);
        check("badpar_count", fifo_count, 0);

        // timeout after 4 data bits, then recovery
        e0 = err_cnt;
        v = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        wait_cyc(TIMEOUT_CYC - 200);
        check("tmo_early", err_cnt - e0, 0);
        wait_cyc(400);
        check("tmo_err", err_cnt - e0, 1);
        send_frame(8'h1C);
        check("tmo_recover_count", fifo_count, 1);
        check("tmo_recover_ascii", cpu_if.ascii_out, 8'h61);
        ack_pulse();

        // overflow, inhibit, simultaneous push/pop when full, wrap
        o0 = ovf_cnt;
        for (int i = 0; i < DEPTH; i++) send_frame(codes[i]);
        check("full_count", fifo_count, DEPTH);
        check("full_pd", ps2_clk_pulldown, 1);
        check("full_head", cpu_if.ascii_out, 8'h61);
        check("full_no_ovf", ovf_cnt - o0, 0);
        send_frame(8'h15);
        check("ovf_pulse", ovf_cnt - o0, 1);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_pd", ps2_clk_pulldown, 1);
        ack_pulse();
        check("rel_pd", ps2_clk_pulldown, 0);
        check("rel_count", fifo_count, DEPTH - 1);
        send_frame(8'h2D);
        check("refill_count", fifo_count, DEPTH);
        o0 = ovf_cnt;
        send_frame(8'h1B, 1'b0, LAT - 1);
        check("pushpop_count", fifo_count, DEPTH);
        check("pushpop_no_ovf", ovf_cnt - o0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d", i), cpu_if.ascii_out, drain[i]);
            ack_pulse();
        end
        check("drain_count", fifo_count, 0);

        // glitch rejection and extended codes
        e0 = err_cnt;
        ps2_data = 1'b0;
        repeat (3) glitch();
        ps2_data = 1'b1;
        wait_cyc(20);
        send_frame(8'hE0);
        ps2_data = 1'b0;
        repeat (2) glitch();
        ps2_data = 1'b1;
        send_frame(8'h5A);
        check("kp_enter_count", fifo_count, 1);
        check("kp_enter_ascii", cpu_if.ascii_out, 8'h0D);
        ack_pulse();
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h5A);
        check("ext_break_count", fifo_count, 0);
        check("glitch_no_err", err_cnt - e0, 0);

        // reset mid-frame with a non-empty FIFO and shift held
        send_frame(8'h12); send_frame(8'h1C);
        check("pre_rst_ascii", cpu_if.ascii_out, 8'h41);
        v = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(v[i]);
        rst = 1'b0;
        wait_cyc(2);
        check("mrst_intr", cpu_if.cpu_intr, 0);
        check("mrst_ascii", cpu_if.ascii_out, 0);
        check("mrst_count", fifo_count, 0);
        check("mrst_flags", {ps2_clk_pulldown, ps2_data_pulldown, rx_err, overflow}, 0);
        rst = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(20);
        send_frame(8'h1C);
        check("post_rst_count", fifo_count, 1);
        check("post_rst_ascii", cpu_if.ascii_out, 8'h61);
        check("post_rst_intr", cpu_if.cpu_intr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
